intp_arb: RTL and testbench

INTP_ARB -- requirements
Module: intp_arb

---
 rtl/intp_arb.sv | 121 ++++++++++++
 tb/tb_intp_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intp_arb.sv
// Interrupt arbiter: picks the highest-priority eligible source, requests the CPU,
// pulses a clear back to the interrupt manager on accept and holds until end-of-interrupt.
module intp_arb #(
    parameter int unsigned SRC_NUM = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SRC_NUM-1:0]     intp_sig_stat,
    input  logic [SRC_NUM-1:0]     intp_sig_mask,
    input  logic [2*SRC_NUM-1:0]   intp_prio,
    output logic                   irq_req,
    output logic [ID_W-1:0]        irq_id,
    input  logic                   irq_ack,
    input  logic                   irq_eoi,
    output logic [SRC_NUM-1:0]     intp_sig_clr,
    output logic                   busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARB  = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;
    localparam logic [1:0] ST_SERV = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               req_q, req_d;
    logic [SRC_NUM-1:0] clr_q, clr_d;

    logic [SRC_NUM-1:0] elig;
    logic               any_elig;
    logic [SRC_NUM-1:0] id_onehot;
    logic               cur_elig;

    logic [ID_W-1:0]    win_id;
    logic [1:0]         win_prio;
    logic               win_found;

    assign elig     = intp_sig_stat & ~intp_sig_mask;
    assign any_elig = |elig;

    // Ascending scan with strict '>' keeps the lowest index on priority ties.
    always_comb begin
        win_id    = '0;
        win_prio  = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < SRC_NUM; i++) begin
            if (elig[i] && (!win_found || (intp_prio[2*i +: 2] > win_prio))) begin
                win_found = 1'b1;
                win_prio  = intp_prio[2*i +: 2];
                win_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        id_onehot = '0;
        for (int unsigned i = 0; i < SRC_NUM; i++) begin
            id_onehot[i] = (id_q == ID_W'(i));
        end
    end

    assign cur_elig = |(elig & id_onehot);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        clr_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (win_found) begin
                    id_d    = win_id;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Accept takes precedence over a simultaneous withdrawal.
                if (irq_ack) begin
                    state_d = ST_SERV;
                    clr_d   = id_onehot;
                end else if (!cur_elig) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERV: begin
                if (irq_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            req_q   <= 1'b0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            req_q   <= req_d;
            clr_q   <= clr_d;
        end
    end

    assign irq_req      = req_q;
    assign irq_id       = id_q;
    assign intp_sig_clr = clr_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_intp_arb.sv
// Self-checking bench for intp_arb: directed vector table, corner-case sequences,
// and randomized traffic compared cycle by cycle against a behavioural model.
module tb_intp_arb;

    localparam int SRC = 8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  stat;
    logic [7:0]  mask;
    logic [15:0] prio;
    logic        ack;
    logic        eoi;
    logic        irq_req;
    logic [2:0]  irq_id;
    logic [7:0]  clr;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    intp_arb #(.SRC_NUM(8), .ID_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .intp_sig_stat(stat),
        .intp_sig_mask(mask),
        .intp_prio    (prio),
        .irq_req      (irq_req),
        .irq_id       (irq_id),
        .irq_ack      (ack),
        .irq_eoi      (eoi),
        .intp_sig_clr (clr),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase of the interrupt handshake, granted source, clear pulse.
    localparam int P_IDLE = 0, P_ARB = 1, P_REQ = 2, P_SERV = 3;
    int         m_phase = P_IDLE;
    int         m_id    = 0;
    logic [7:0] m_clr   = '0;

    function automatic int winner(input logic [7:0] e, input logic [15:0] p);
        int best = -1;
        int best_score = -1;
        for (int i = 0; i < SRC; i++) begin
            if (e[i]) begin
                int score = int'(p[2*i +: 2]) * 16 + (15 - i);
                if (score > best_score) begin
                    best_score = score;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_step();
        logic [7:0] e;
        int w;
        e = stat & ~mask;
        m_clr = '0;
        if (!rst_n) begin
            m_phase = P_IDLE;
            m_id    = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (e != 0) m_phase = P_ARB;
                P_ARB: begin
                    w = winner(e, prio);
                    if (w >= 0) begin
                        m_id = w;
                        m_phase = P_REQ;
                    end else begin
                        m_phase = P_IDLE;
                    end
                end
                P_REQ: begin
                    if (ack) begin
                        m_clr = 8'(1) << m_id;
                        m_phase = P_SERV;
                    end else if (!e[m_id]) begin
                        m_phase = P_IDLE;
                    end
                end
                default: if (eoi) m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_req",  32'(irq_req), 32'(m_phase == P_REQ));
        chk("model_busy", 32'(busy),    32'(m_phase != P_IDLE));
        chk("model_id",   32'(irq_id),  32'(m_id));
        chk("model_clr",  32'(clr),     32'(m_clr));
    endtask

    typedef struct {
        logic [7:0]  stat;
        logic [7:0]  mask;
        logic [15:0] prio;
        logic [2:0]  exp_id;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{stat: 8'h04, mask: 8'h00, prio: 16'h0000, exp_id: 3'd2};
        vecs[1] = '{stat: 8'h21, mask: 8'h00, prio: 16'h0801, exp_id: 3'd5};
        vecs[2] = '{stat: 8'h03, mask: 8'h00, prio: 16'h0000, exp_id: 3'd0};
        vecs[3] = '{stat: 8'hFF, mask: 8'h00, prio: 16'hFFFF, exp_id: 3'd0};
        vecs[4] = '{stat: 8'hFF, mask: 8'h01, prio: 16'hFFFF, exp_id: 3'd1};
        vecs[5] = '{stat: 8'h80, mask: 8'h00, prio: 16'h0000, exp_id: 3'd7};
        vecs[6] = '{stat: 8'hC0, mask: 8'h00, prio: 16'hD000, exp_id: 3'd7};
        vecs[7] = '{stat: 8'h0A, mask: 8'h00, prio: 16'h0088, exp_id: 3'd1};
        vecs[8] = '{stat: 8'h12, mask: 8'h02, prio: 16'h030C, exp_id: 3'd4};

        rst_n = 1'b0; stat = '0; mask = '0; prio = '0; ack = 1'b0; eoi = 1'b0;
        #1;
        chk("rst_req", 32'(irq_req), 0);
        chk("rst_id", 32'(irq_id), 0);
        chk("rst_clr", 32'(clr), 0);
        chk("rst_busy", 32'(busy), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("idle_quiet", 32'(busy), 0);

        // Full handshake for each vector: IDLE -> ARB -> REQ -> SERV -> IDLE.
        for (int v = 0; v < 9; v++) begin
            stat = vecs[v].stat; mask = vecs[v].mask; prio = vecs[v].prio;
            tick();
            chk("vec_arb_busy", 32'(busy), 1);
            chk("vec_arb_noreq", 32'(irq_req), 0);
            tick();
            chk("vec_req", 32'(irq_req), 1);
            chk("vec_id", 32'(irq_id), 32'(vecs[v].exp_id));
            ack = 1'b1;
            tick();
            ack = 1'b0; stat = '0;
            chk("vec_clr", 32'(clr), 32'(8'(1) << vecs[v].exp_id));
            chk("vec_serv_noreq", 32'(irq_req), 0);
            tick();
            chk("vec_clr_once", 32'(clr), 0);
            eoi = 1'b1;
            tick();
            eoi = 1'b0;
            chk("vec_eoi_idle", 32'(busy), 0);
        end
        mask = '0; prio = '0;

        // Withdrawal without ack.
        stat = 8'h08;
        tick(); tick();
        chk("wd_req", 32'(irq_req), 1);
        mask = 8'h08;
        tick();
        chk("wd_req_drop", 32'(irq_req), 0);
        chk("wd_no_clr", 32'(clr), 0);
        chk("wd_idle", 32'(busy), 0);
        tick();
        chk("wd_stay_idle", 32'(busy), 0);
        // Withdrawal coincident with ack counts as ack.
        mask = 8'h00;
        tick(); tick();
        chk("wd2_req", 32'(irq_req), 1);
        mask = 8'h08; ack = 1'b1;
        tick();
        ack = 1'b0; stat = '0; mask = '0;
        chk("wd2_clr", 32'(clr), 32'h08);
        chk("wd2_serv", 32'(busy), 1);
        eoi = 1'b1; tick(); eoi = 1'b0;

        // No preemption while in service.
        stat = 8'h02;
        tick(); tick();
        chk("np_id1", 32'(irq_id), 1);
        ack = 1'b1; tick(); ack = 1'b0;
        stat = 8'h82; prio = 16'hC000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("np_hold_id", 32'(irq_id), 1);
            chk("np_hold_req", 32'(irq_req), 0);
            chk("np_hold_busy", 32'(busy), 1);
        end
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        tick();
        chk("np_id7", 32'(irq_id), 7);
        chk("np_req7", 32'(irq_req), 1);
        ack = 1'b1; tick(); ack = 1'b0; stat = '0; prio = '0;
        eoi = 1'b1; tick(); eoi = 1'b0;

        // Eligibility vanishing during ARB keeps the previous id.
        stat = 8'h01;
        tick();
        stat = 8'h00;
        tick();
        chk("arb_empty_idle", 32'(busy), 0);
        chk("arb_empty_id", 32'(irq_id), 7);

        // Asynchronous reset in REQ and in SERV.
        stat = 8'h04;
        tick(); tick();
        chk("rr_req", 32'(irq_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_async_req", 32'(irq_req), 0);
        chk("rr_async_id", 32'(irq_id), 0);
        chk("rr_async_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("rs_clr_pulse", 32'(clr), 32'h04);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async_clr", 32'(clr), 0);
        chk("rs_async_busy", 32'(busy), 0);
        chk("rs_async_id", 32'(irq_id), 0);
        tick();
        rst_n = 1'b1; stat = '0;

        // ack / eoi in IDLE are ignored.
        ack = 1'b1; eoi = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_ign_busy", 32'(busy), 0);
            chk("idle_ign_clr", 32'(clr), 0);
        end
        ack = 1'b0; eoi = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            stat = 8'($urandom) & 8'($urandom);
            mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(7) == 0) prio = 16'($urandom);
            ack = ($urandom_range(3) == 0);
            eoi = ($urandom_range(3) == 0);
            rst_n = ($urandom_range(149) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
